// File: rtl/flex_serializer.sv
// Parallel-to-serial converter with a runtime word length and a one-word holding buffer.
// A word is accepted from the input or the buffer on the last bit cycle, so consecutive words shift out with no gap.
module flex_serializer #(
  parameter int DATA_W    = 16,
  parameter int MOD_W     = $clog2(DATA_W),
  parameter int MIN_LEN   = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o,
  output logic              drop_o
);

  localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] MIN_L    = (MOD_W+1)'(MIN_LEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [MOD_W:0]    bit_cnt;
  logic [DATA_W-1:0] buf_data;
  logic [MOD_W:0]    buf_len;
  logic              buf_full;

  logic [MOD_W:0]    in_len;
  logic              accept;
  logic              in_short;

  assign in_len   = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};
  assign accept   = data_val_i && !buf_full;
  assign in_short = in_len < MIN_L;
  assign ready_o  = !buf_full;
  assign busy_o   = (state == SHIFT) || buf_full;

  function automatic logic first_bit(input logic [DATA_W-1:0] d);
    return MSB_FIRST ? d[DATA_W-1] : d[0];
  endfunction

  function automatic logic [DATA_W-1:0] rest_bits(input logic [DATA_W-1:0] d);
    return MSB_FIRST ? (d << 1) : (d >> 1);
  endfunction

  // bit_cnt holds the number of bits still to follow the one currently on ser_data_o.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state          <= IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      buf_data       <= '0;
      buf_len        <= '0;
      buf_full       <= 1'b0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      drop_o         <= 1'b0;
    end else begin
      drop_o <= accept && in_short;
      case (state)
        IDLE: begin
          if (accept && !in_short) begin
            ser_data_o     <= first_bit(data_i);
            ser_data_val_o <= 1'b1;
            shift_reg      <= rest_bits(data_i);
            bit_cnt        <= in_len - 1'b1;
            state          <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            ser_data_o <= first_bit(shift_reg);
            shift_reg  <= rest_bits(shift_reg);
            bit_cnt    <= bit_cnt - 1'b1;
            if (accept && !in_short) begin
              buf_data <= data_i;
              buf_len  <= in_len;
              buf_full <= 1'b1;
            end
          end else if (buf_full) begin
            ser_data_o <= first_bit(buf_data);
            shift_reg  <= rest_bits(buf_data);
            bit_cnt    <= buf_len - 1'b1;
            buf_full   <= 1'b0;
          end else if (accept && !in_short) begin
            ser_data_o <= first_bit(data_i);
            shift_reg  <= rest_bits(data_i);
            bit_cnt    <= in_len - 1'b1;
          end else begin
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            state          <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flex_serializer.sv
// Directed self-checking bench for flex_serializer: one MSB-first and one LSB-first instance.
module tb_flex_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] data = '0;
  logic [3:0]  mod = '0;
  logic        val = 1'b0;
  logic        ready, sdata, sval, busy, drop;

  logic [15:0] data2 = '0;
  logic [3:0]  mod2 = '0;
  logic        val2 = 1'b0;
  logic        ready2, sdata2, sval2, busy2, drop2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flex_serializer u_msb (
    .clk_i(clk), .arst_n_i(rst_n), .data_i(data), .data_mod_i(mod), .data_val_i(val),
    .ready_o(ready), .ser_data_o(sdata), .ser_data_val_o(sval), .busy_o(busy), .drop_o(drop)
  );

  flex_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .arst_n_i(rst_n), .data_i(data2), .data_mod_i(mod2), .data_val_i(val2),
    .ready_o(ready2), .ser_data_o(sdata2), .ser_data_val_o(sval2), .busy_o(busy2), .drop_o(drop2)
  );

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({sdata, sval, busy, drop, ready} !== 5'b00001) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got sdata/sval/busy/drop/ready=%b expected 00001",
               {sdata, sval, busy, drop, ready});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_word;
    logic [15:0] exp;
    exp = 16'hA5C3;
    data = 16'hA5C3; mod = 4'd0; val = 1'b1;
    @(negedge clk);
    val = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (sval !== 1'b1 || sdata !== exp[15-i]) begin
        n_fail++;
        $display("[TB] FAIL full_word bit %0d: got val=%b data=%b expected val=1 data=%b",
                 i, sval, sdata, exp[15-i]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sval !== 1'b0 || busy !== 1'b0 || sdata !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_word_end: got val=%b busy=%b data=%b expected 0 0 0", sval, busy, sdata);
    end
  endtask

  task automatic test_short_word;
    data = 16'hF800; mod = 4'd5; val = 1'b1;
    @(negedge clk);
    val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (sval !== 1'b1 || sdata !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL short_word bit %0d: got val=%b data=%b expected val=1 data=1", i, sval, sdata);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sval !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL short_word_end: got val=%b busy=%b expected 0 0", sval, busy);
    end
  endtask

  task automatic test_drop;
    logic [2:0] exp;
    data = 16'hFFFF; mod = 4'd2; val = 1'b1;
    @(negedge clk);
    val = 1'b0;
    n_cmp++;
    if (drop !== 1'b1 || sval !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_pulse: got drop=%b val=%b busy=%b expected 1 0 0", drop, sval, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (drop !== 1'b0 || sval !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_after: got drop=%b val=%b busy=%b expected 0 0 0", drop, sval, busy);
    end
    exp = 3'b011;
    data = 16'h6000; mod = 4'd3; val = 1'b1;
    @(negedge clk);
    val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (sval !== 1'b1 || sdata !== exp[2-i] || drop !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL min_len bit %0d: got val=%b data=%b drop=%b expected 1 %b 0",
                 i, sval, sdata, drop, exp[2-i]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sval !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL min_len_end: got val=%b busy=%b expected 0 0", sval, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_bits;
    logic [7:0] exp_rdy;
    exp_bits = 8'b10100101;
    exp_rdy  = 8'b10001111;
    data = 16'hA000; mod = 4'd4; val = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (sval !== 1'b1 || sdata !== exp_bits[7-i] || ready !== exp_rdy[7-i] || busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL back_to_back cycle %0d: got val=%b data=%b ready=%b busy=%b expected 1 %b %b 1",
                 i, sval, sdata, ready, busy, exp_bits[7-i], exp_rdy[7-i]);
      end
      if (i == 0) begin
        data = 16'h5000; mod = 4'd4; val = 1'b1;
      end else begin
        val = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sval !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL back_to_back_end: got val=%b busy=%b ready=%b expected 0 0 1", sval, busy, ready);
    end
  endtask

  task automatic test_last_cycle_load;
    logic [5:0] exp;
    exp = 6'b111000;
    data = 16'hE000; mod = 4'd3; val = 1'b1;
    @(negedge clk);
    val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (sval !== 1'b1 || sdata !== exp[5-i] || ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL last_cycle_load cycle %0d: got val=%b data=%b ready=%b expected 1 %b 1",
                 i, sval, sdata, ready, exp[5-i]);
      end
      if (i == 2) begin
        data = 16'h0000; mod = 4'd3; val = 1'b1;
      end else begin
        val = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sval !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL last_cycle_load_end: got val=%b busy=%b expected 0 0", sval, busy);
    end
  endtask

  task automatic test_reset_mid_word;
    data = 16'hFFFF; mod = 4'd0; val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    val = 1'b0;
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_buffered: got ready=%b busy=%b expected 0 1", ready, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (sval !== 1'b1 || sdata !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_third_bit: got val=%b data=%b expected 1 1", sval, sdata);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sdata, sval, busy, drop, ready} !== 5'b00001) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_async: got sdata/sval/busy/drop/ready=%b expected 00001",
               {sdata, sval, busy, drop, ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sval !== 1'b0 || busy !== 1'b0 || sdata !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_after cycle %0d: got val=%b busy=%b data=%b expected 0 0 0",
                 i, sval, busy, sdata);
      end
    end
  endtask

  task automatic test_lsb_first;
    logic [3:0] exp;
    exp = 4'b1100;
    data2 = 16'h0003; mod2 = 4'd4; val2 = 1'b1;
    @(negedge clk);
    val2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (sval2 !== 1'b1 || sdata2 !== exp[3-i]) begin
        n_fail++;
        $display("[TB] FAIL lsb_first bit %0d: got val=%b data=%b expected 1 %b", i, sval2, sdata2, exp[3-i]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sval2 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL lsb_first_end: got val=%b busy=%b expected 0 0", sval2, busy2);
    end
  endtask

  initial begin
    test_reset;
    test_full_word;
    test_short_word;
    test_drop;
    test_back_to_back;
    test_last_cycle_load;
    test_reset_mid_word;
    test_lsb_first;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/flex_serializer.md
FLEX_SERIALIZER -- requirements
Module: flex_serializer

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 16, giving the parallel word width (legal values 4..64).
REQ-002 The block SHALL have a parameter MOD_W, default $clog2(DATA_W), giving the width of data_mod_i.
REQ-003 The block SHALL have a parameter MIN_LEN, default 3, giving the minimum legal word length in bits.
REQ-004 The block SHALL have a parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = shift LSB first.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 The block SHALL have port arst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port data_i, input, DATA_W bits: parallel word.
REQ-008 The block SHALL have port data_mod_i, input, MOD_W bits: word length; 0 means DATA_W.
REQ-009 The block SHALL have port data_val_i, input, 1 bit: input word valid.
REQ-010 The block SHALL have port ready_o, output, 1 bit: the block can accept a word this cycle.
REQ-011 The block SHALL have port ser_data_o, output, 1 bit: serial data bit.
REQ-012 The block SHALL have port ser_data_val_o, output, 1 bit: ser_data_o is valid.
REQ-013 The block SHALL have port busy_o, output, 1 bit: a word is shifting or buffered.
REQ-014 The block SHALL have port drop_o, output, 1 bit: one-cycle pulse when an accepted word is discarded.

Function
REQ-015 A word SHALL be accepted on any rising edge where data_val_i=1 and ready_o=1; data_val_i while ready_o=0 SHALL be ignored, and upstream holds the word.
REQ-016 Length L SHALL be DATA_W when data_mod_i=0, otherwise data_mod_i.
REQ-017 An accepted word with L<MIN_LEN SHALL be discarded: drop_o=1 for the following cycle, with no change to the shifter, buffer or busy_o.
REQ-018 For MSB_FIRST=1 the emitted bits SHALL be data_i[DATA_W-1] down to data_i[DATA_W-L]; for MSB_FIRST=0 they SHALL be data_i[0] up to data_i[L-1].
REQ-019 The block SHALL use states IDLE and SHIFT plus a one-entry holding buffer (buf_full flag).
REQ-020 When a word is accepted in IDLE at edge k, ser_data_val_o SHALL be 1 for exactly L consecutive cycles starting after edge k, and the state SHALL go to SHIFT.
REQ-021 ser_data_o SHALL be 0 whenever ser_data_val_o=0.
REQ-022 ready_o SHALL equal !buf_full, taken directly from a register with no combinational path from data_val_i.
REQ-023 A word accepted while in SHIFT SHALL be stored in the buffer and set buf_full.
REQ-024 On the last bit cycle, if buf_full=1, the buffered word SHALL load into the shifter with no idle cycle and buf_full SHALL clear.
REQ-025 On the last bit cycle, if buf_full=0 and a word is accepted on that edge, it SHALL load directly into the shifter with no gap.
REQ-026 On the last bit cycle with no buffered and no incoming word, the state SHALL return to IDLE.
REQ-027 busy_o SHALL be 1 whenever state=SHIFT or buf_full=1, and 0 otherwise.
REQ-028 The bit counter SHALL be MOD_W+1 bits wide so that L=DATA_W counts without wrap.

Reset
REQ-029 While arst_n_i=0, the block SHALL immediately, without waiting for a clock edge, force ser_data_o=0, ser_data_val_o=0, busy_o=0, drop_o=0, ready_o=1, state=IDLE and buf_full=0.
REQ-030 Reset asserted mid-word SHALL abort the current word and flush the buffer; no partial word SHALL resume after release.
REQ-031 The first acceptance SHALL be possible on the first rising edge after arst_n_i deasserts.

Verification (DATA_W=16, MIN_LEN=3, MSB_FIRST=1 unless stated)
REQ-032 The bench SHALL drive data_i=0xA5C3, mod=0 -> 16 valid cycles 1010010111000011, then busy_o=0.
REQ-033 The bench SHALL drive data_i=0xF800, mod=5 -> 5 valid cycles 11111, then ser_data_val_o=0.
REQ-034 The bench SHALL drive mod=2, any data -> drop_o one-cycle pulse, no valid output, busy_o stays 0.
REQ-035 The bench SHALL drive back-to-back 0xA000 mod=4 then 0x5000 mod=4 -> 8 contiguous valid cycles 10100101, with ready_o=0 while the second word is buffered.
REQ-036 The bench SHALL assert arst_n_i=0 during the third bit of a 16-bit word with a word buffered -> all outputs 0 and ready_o=1 at once, and no further bits after release.
REQ-037 The bench SHALL set MSB_FIRST=0 and drive data_i=0x0003, mod=4 -> 4 valid cycles 1100.
